// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters for the renderer, with blanked colour and syncs registered in step for the VGA pins
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       pixel_tick,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          h_end, v_end;
  assign h_end       = h_q == H_MAX;
  assign v_end       = v_q == V_MAX;
  assign pixel_tick  = div_q == DIV_MAX;
  assign video_on    = h_q < H_VIS && v_q < V_VIS;
  assign frame_start = pixel_tick && h_end && v_end;
  // Everything advances only on the tick, so the registered outputs describe the pixel just sampled
  always_comb begin
    div_d = pixel_tick ? '0 : div_q + DW'(1);
    h_d   = pixel_tick ? (h_end ? '0 : h_q + 10'd1) : h_q;
    v_d   = (pixel_tick && h_end) ? (v_end ? '0 : v_q + 10'd1) : v_q;
    hs_d  = pixel_tick ? ~(h_q >= HS_BEG && h_q < HS_END) : hs_q;
    vs_d  = pixel_tick ? ~(v_q >= VS_BEG && v_q < VS_END) : vs_q;
    rgb_d = pixel_tick ? (video_on ? rgb_in : 3'b000) : rgb_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= 3'b000;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end
  assign HCount = h_q;
  assign VCount = v_q;
  assign hsync  = hs_q;
  assign vsync  = vs_q;
  assign rgb    = rgb_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: full-size 640x480 instance against a cycle model, plus a tiny PIX_DIV=1 instance for whole-frame timing
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic reset = 1'b1, reset_b = 1'b1, mode_a = 1'b0;
  logic [2:0] rgb_in_a, rgb_in_b, rgb_a, rgb_b;
  logic [9:0] hc_a, vc_a, hc_b, vc_b;
  logic tick_a, von_a, fs_a, hs_a, vs_a;
  logic tick_b, von_b, fs_b, hs_b, vs_b;
  int n_cmp = 0, n_bad = 0, cycle = 0;
  int mdiv = 0, mh = 0, mv = 0, tick_cnt = 0, hs_low = 0;
  logic [4:0] exp_out = 5'b00011;
  logic [4:0] sbq[$];
  int last_fs = -1, vs_low_b = 0, rgb1_b = 0, last_h0b = -1;

  always #5 clk = ~clk;

  assign rgb_in_a = mode_a ? (hc_a[2:0] ^ vc_a[2:0]) : 3'b001;
  assign rgb_in_b = 3'b001;

  vga_sync_gen u_a (
    .clk(clk), .reset(reset), .rgb_in(rgb_in_a), .HCount(hc_a), .VCount(vc_a),
    .pixel_tick(tick_a), .video_on(von_a), .frame_start(fs_a),
    .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIX_DIV(1)
  ) u_b (
    .clk(clk), .reset(reset_b), .rgb_in(rgb_in_b), .HCount(hc_b), .VCount(vc_b),
    .pixel_tick(tick_b), .video_on(von_b), .frame_start(fs_b),
    .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rfn(input int h, input int v);
    return mode_a ? 3'((h ^ v) & 7) : 3'b001;
  endfunction

  task automatic cyc();
    logic ra, rb, tk;
    logic [4:0] e;
    ra = reset;
    rb = reset_b;
    tk = !ra && mdiv == 1;
    e = {(mh < 640 && mv < 480) ? rfn(mh, mv) : 3'b000,
         !(mh >= 656 && mh < 752), !(mv >= 490 && mv < 492)};
    @(posedge clk);
    #1;
    cycle++;
    if (ra) begin
      mdiv = 0; mh = 0; mv = 0; tick_cnt = 0; hs_low = 0;
      sbq.delete();
      exp_out = 5'b00011;
    end else if (tk) begin
      sbq.push_back(e);
      mdiv = 0;
      if (mh == 799) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end
      else mh++;
      exp_out = sbq.pop_front();
      tick_cnt++;
      if (!hs_a) hs_low++;
      if (hc_a == 10'd0) begin
        chk("a_line_ticks", tick_cnt, 800);
        chk("a_hsync_low_ticks", hs_low, 96);
        tick_cnt = 0; hs_low = 0;
      end
    end else mdiv++;
    chk("a_hcount", 32'(hc_a), mh);
    chk("a_vcount", 32'(vc_a), mv);
    chk("a_pixel_tick", 32'(tick_a), 32'(mdiv == 1));
    chk("a_video_on", 32'(von_a), 32'(mh < 640 && mv < 480));
    chk("a_frame_start", 32'(fs_a), 32'(mdiv == 1 && mh == 799 && mv == 524));
    chk("a_rgb_hs_vs", 32'({rgb_a, hs_a, vs_a}), 32'(exp_out));
    if (rb) begin
      chk("b_rst_hcount", 32'(hc_b), 0);
      chk("b_rst_vcount", 32'(vc_b), 0);
      chk("b_rst_syncs", 32'({hs_b, vs_b}), 3);
      chk("b_rst_rgb", 32'(rgb_b), 0);
      chk("b_rst_frame_start", 32'(fs_b), 0);
      last_fs = -1; last_h0b = -1; vs_low_b = 0; rgb1_b = 0;
    end else begin
      chk("b_pixel_tick", 32'(tick_b), 1);
      if (!vs_b) vs_low_b++;
      if (rgb_b == 3'b001) rgb1_b++;
      if (fs_b) begin
        if (last_fs >= 0) begin
          chk("b_frame_gap", cycle - last_fs, 120);
          chk("b_vsync_low", vs_low_b, 30);
          chk("b_rgb_on", rgb1_b, 32);
        end
        last_fs = cycle; vs_low_b = 0; rgb1_b = 0;
      end
      if (hc_b == 10'd0) begin
        if (last_h0b >= 0) chk("b_line_clks", cycle - last_h0b, 15);
        last_h0b = cycle;
      end
    end
  endtask

  initial begin
    int k;
    repeat (3) cyc();
    reset = 1'b0;
    reset_b = 1'b0;
    repeat (3300) cyc();
    mode_a = 1'b1;
    repeat (1700) cyc();
    k = 0;
    while (hc_a != 10'd300 && k < 4000) begin cyc(); k++; end
    chk("a_seek_h300", 32'(hc_a), 300);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (3300) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
